// File: rtl/uart_msg_tx.sv
// rtl/uart_msg_tx.sv - button-triggered UART 8N1 transmitter walking a registered-read byte RAM
module uart_msg_tx #(
    parameter int RAM_SIZE        = 16,
    parameter int CLK_FREQ        = 44,
    parameter int BAUD_RATE       = 115200,
    parameter int DEBOUNCE_CYCLES = 440000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        BTNTX,
    output logic [$clog2(RAM_SIZE)-1:0] ram_rdaddr,
    input  logic [7:0]                  ram_dout,
    output logic                        tx_out,
    output logic                        busy
);
    localparam int AW       = $clog2(RAM_SIZE);
    localparam int BAUD_DIV = (CLK_FREQ * 1_000_000 + BAUD_RATE / 2) / BAUD_RATE;
    localparam int BW       = $clog2(BAUD_DIV + 1);
    localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_START, S_DATA, S_STOP
    } state_t;

    logic [1:0]    r_sync;
    logic          r_btn_lvl;
    logic [DW-1:0] r_db_cnt;
    logic          r_trigger;

    state_t        r_state, w_state_next;
    logic [AW-1:0] r_addr, w_addr_next;
    logic [7:0]    r_shift, w_shift_next;
    logic [BW-1:0] r_baud_cnt, w_baud_cnt_next;
    logic [2:0]    r_bit_cnt, w_bit_cnt_next;
    logic          r_tx, w_tx_next;
    logic          w_baud_done;

    // Synchronise the raw button, debounce it, and pulse r_trigger on an accepted rising level.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_btn_lvl <= 1'b0;
            r_db_cnt  <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], BTNTX};
            r_trigger <= 1'b0;
            if (r_sync[1] == r_btn_lvl) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                r_btn_lvl <= r_sync[1];
                r_db_cnt  <= '0;
                r_trigger <= r_sync[1];
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign w_baud_done = (r_baud_cnt == BW'(BAUD_DIV - 1));

    // Next-state and datapath update; tx is computed one step ahead so the pin comes straight from a flop.
    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_shift_next    = r_shift;
        w_baud_cnt_next = '0;
        w_bit_cnt_next  = r_bit_cnt;
        w_tx_next       = r_tx;
        case (r_state)
            S_IDLE: begin
                w_addr_next = '0;
                w_tx_next   = 1'b1;
                if (r_trigger) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_LOAD;
            S_LOAD: begin
                if (ram_dout == 8'h00) begin
                    w_state_next = S_IDLE;
                    w_addr_next  = '0;
                end else begin
                    w_shift_next = ram_dout;
                    w_tx_next    = 1'b0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_done) begin
                    w_tx_next      = r_shift[0];
                    w_bit_cnt_next = 3'd0;
                    w_state_next   = S_DATA;
                end else begin
                    w_baud_cnt_next = r_baud_cnt + BW'(1);
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
                    end else begin
                        w_tx_next      = r_shift[1];
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + BW'(1);
                end
            end
            S_STOP: begin
                if (w_baud_done) begin
                    if (r_addr == AW'(RAM_SIZE - 1)) begin
                        w_addr_next  = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_addr_next  = r_addr + AW'(1);
                        w_state_next = S_FETCH;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + BW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_addr_next  = '0;
                w_tx_next    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset abandons any frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_shift    <= 8'h00;
            r_baud_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_shift    <= w_shift_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tx       <= w_tx_next;
        end
    end

    assign ram_rdaddr = r_addr;
    assign tx_out     = r_tx;
    assign busy       = (r_state != S_IDLE);

endmodule
